jtag_mailbox_ctrl: RTL and testbench

Command sequencer that sits between the JTAG register bank and an on-chip register bus. It watches one host-written JTAG register for new commands, executes each as a single read or write on the local bus, and reports status and read data through two host-readable JTAG registers. The host can then poke FPGA internals over JTAG without dedicating one JTAG register per internal signal.

---
 rtl/jtag_mailbox_pkg.sv | 21 ++
 rtl/jtag_mailbox_ctrl.sv | 117 +++++++++++
 tb/tb_jtag_mailbox_ctrl.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/jtag_mailbox_pkg.sv
// Shared encodings for the JTAG mailbox sequencer: opcodes, results,
// command/status field positions and the FSM state type.
package jtag_mailbox_pkg;
  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_BAD   = 2'b11;

  localparam logic [1:0] RES_OK      = 2'b00;
  localparam logic [1:0] RES_TIMEOUT = 2'b01;
  localparam logic [1:0] RES_BADOP   = 2'b10;

  localparam int TAG_LSB  = 24;
  localparam int TAG_W    = 8;
  localparam int OP_LSB   = 22;
  localparam int RES_LSB  = 22;
  localparam int BUSY_BIT = 21;
  localparam int CNT_W    = 16;

  typedef enum logic [1:0] {IDLE, QUAL, ACCESS, DONE} state_t;
endpackage

// File: rtl/jtag_mailbox_ctrl.sv
// Turns host-written JTAG command words into single local-bus reads/writes
// and reports tag, result, busy and completion count back over JTAG.
module jtag_mailbox_ctrl
  import jtag_mailbox_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 1023
) (
  input  logic              iMAIN_CLK,
  input  logic              iRESET,
  input  logic [WIDTH-1:0]  iCMD,
  input  logic [WIDTH-1:0]  iWDATA,
  output logic [WIDTH-1:0]  oSTATUS,
  output logic [WIDTH-1:0]  oRDATA,
  output logic [ADDR_W-1:0] oBUS_ADDR,
  output logic [WIDTH-1:0]  oBUS_WDATA,
  output logic              oBUS_WE,
  output logic              oBUS_RE,
  input  logic [WIDTH-1:0]  iBUS_RDATA,
  input  logic              iBUS_ACK
);
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  state_t             state, nextState;
  logic [WIDTH-1:0]   cmdQ, wdQ, rdQ, rdataQ;
  logic [TAG_W-1:0]   lastTag;
  logic [1:0]         resQ, lastRes;
  logic [CNT_W-1:0]   doneCnt;
  logic [TMR_W-1:0]   tmr;
  logic               newTag, qualOk, tmo;
  logic [1:0]         op;

  assign newTag = iCMD[TAG_LSB +: TAG_W] != lastTag;
  // Both words must read back identical to what was captured one cycle
  // earlier, so a half-shifted JTAG update never reaches the bus.
  assign qualOk = (iCMD == cmdQ) && (iWDATA == wdQ);
  assign op     = cmdQ[OP_LSB +: 2];
  assign tmo    = tmr == TMR_W'(TIMEOUT - 1);

  always_ff @(posedge iMAIN_CLK or posedge iRESET) begin
    if (iRESET) state <= IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:   if (newTag) nextState = QUAL;
      QUAL:   if (qualOk) nextState = (op == OP_WRITE || op == OP_READ) ? ACCESS : DONE;
      ACCESS: if (iBUS_ACK || tmo) nextState = DONE;
      DONE:   nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    oBUS_WE = (state == ACCESS) && (op == OP_WRITE);
    oBUS_RE = (state == ACCESS) && (op == OP_READ);
    oSTATUS = '0;
    oSTATUS[TAG_LSB +: TAG_W] = lastTag;
    oSTATUS[RES_LSB +: 2]     = lastRes;
    oSTATUS[BUSY_BIT]         = state != IDLE;
    oSTATUS[CNT_W-1:0]        = doneCnt;
  end

  assign oBUS_ADDR  = cmdQ[ADDR_W-1:0];
  assign oBUS_WDATA = wdQ;
  assign oRDATA     = rdataQ;

  always_ff @(posedge iMAIN_CLK or posedge iRESET) begin
    if (iRESET) begin
      cmdQ    <= '0;
      wdQ     <= '0;
      rdQ     <= '0;
      rdataQ  <= '0;
      lastTag <= '0;
      resQ    <= RES_OK;
      lastRes <= RES_OK;
      doneCnt <= '0;
      tmr     <= '0;
    end else begin
      case (state)
        IDLE: if (newTag) begin
          cmdQ <= iCMD;
          wdQ  <= iWDATA;
        end
        QUAL: begin
          tmr <= '0;
          if (!qualOk) begin
            cmdQ <= iCMD;
            wdQ  <= iWDATA;
          end else begin
            resQ <= (op == OP_BAD) ? RES_BADOP : RES_OK;
          end
        end
        ACCESS: begin
          tmr <= tmr + TMR_W'(1);
          if (iBUS_ACK) begin
            resQ <= RES_OK;
            if (op == OP_READ) rdQ <= iBUS_RDATA;
          end else if (tmo) begin
            resQ <= RES_TIMEOUT;
          end
        end
        DONE: begin
          lastTag <= cmdQ[TAG_LSB +: TAG_W];
          lastRes <= resQ;
          doneCnt <= doneCnt + CNT_W'(1);
          // Read data is published together with the status word.
          if (op == OP_READ && resQ == RES_OK) rdataQ <= rdQ;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_jtag_mailbox_ctrl.sv
// Directed checks of the JTAG mailbox sequencer with hand-computed values.
module tb_jtag_mailbox_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cmd, wdata, status, rdata, busWdata, busRdata;
  logic [15:0] busAddr;
  logic        we, re, ack;
  int          nCmp = 0, nBad = 0;

  jtag_mailbox_ctrl #(.WIDTH(32), .ADDR_W(16), .TIMEOUT(8)) dut (
    .iMAIN_CLK(clk), .iRESET(rst), .iCMD(cmd), .iWDATA(wdata),
    .oSTATUS(status), .oRDATA(rdata), .oBUS_ADDR(busAddr),
    .oBUS_WDATA(busWdata), .oBUS_WE(we), .oBUS_RE(re),
    .iBUS_RDATA(busRdata), .iBUS_ACK(ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCmp++;
    if (got !== exp) begin
      nBad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int cnt;

  initial begin
    rst = 1'b1; cmd = '0; wdata = '0; busRdata = '0; ack = 1'b0;
    #12;
    chk("rst_status", status, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_strobes", {30'b0, we, re}, 32'h0);
    chk("rst_addr", {16'b0, busAddr}, 32'h0);
    step(); rst = 1'b0; step(); step();
    chk("tag0_ignored", status, 32'h0);

    // WRITE tag 01, ack in cycle 3
    cmd = 32'h0140_0010; wdata = 32'hDEADBEEF;
    step();                                   // cycle 1
    chk("wr_c1_we", {31'b0, we}, 32'h0);
    chk("wr_c1_busy", status, 32'h0020_0000);
    step();                                   // cycle 2
    chk("wr_c2_we", {31'b0, we}, 32'h1);
    chk("wr_c2_addr", {16'b0, busAddr}, 32'h10);
    chk("wr_c2_data", busWdata, 32'hDEADBEEF);
    step(); ack = 1'b1;                       // cycle 3
    chk("wr_c3_we", {31'b0, we}, 32'h1);
    step(); ack = 1'b0;                       // cycle 4
    chk("wr_c4_we", {31'b0, we}, 32'h0);
    step();                                   // cycle 5
    chk("wr_status", status, 32'h0100_0001);

    // READ tag 02, immediate ack
    cmd = 32'h0280_0020; busRdata = 32'h12345678;
    step(); step();                           // cycle 2
    chk("rd_re", {31'b0, re}, 32'h1);
    chk("rd_we", {31'b0, we}, 32'h0);
    chk("rd_addr", {16'b0, busAddr}, 32'h20);
    ack = 1'b1;
    step(); ack = 1'b0; busRdata = 32'h0;     // cycle 3
    chk("rd_c3_re", {31'b0, re}, 32'h0);
    chk("rd_c3_rdata_old", rdata, 32'h0);
    step();                                   // cycle 4
    chk("rd_rdata", rdata, 32'h12345678);
    chk("rd_status", status, 32'h0200_0002);

    // READ tag 03 never acked
    cmd = 32'h0380_0030; busRdata = 32'hAAAA5555; cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (re) cnt++;
      step();
    end
    chk("to_re_cycles", cnt, 32'd8);
    chk("to_status", status, 32'h0340_0003);
    chk("to_rdata_kept", rdata, 32'h12345678);

    // torn update: tag 04 then tag 06 on consecutive cycles
    cmd = 32'h0440_0040; wdata = 32'h1111;
    step(); cmd = 32'h0640_0044; wdata = 32'h2222;   // cycle 1
    chk("torn_c1_we", {31'b0, we}, 32'h0);
    step();                                          // cycle 2
    chk("torn_c2_we", {31'b0, we}, 32'h0);
    step();                                          // cycle 3
    chk("torn_c3_we", {31'b0, we}, 32'h1);
    chk("torn_addr", {16'b0, busAddr}, 32'h44);
    chk("torn_data", busWdata, 32'h2222);
    ack = 1'b1;
    step(); ack = 1'b0; cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (we || re) cnt++;
      step();
    end
    chk("torn_single_access", cnt, 32'd0);
    chk("torn_status", status, 32'h0600_0004);

    // reserved opcode, tag 05
    cmd = 32'h05C0_0050; cnt = 0;
    for (int i = 0; i < 3; i++) begin
      if (we || re) cnt++;
      step();
    end
    chk("bad_status", status, 32'h0580_0005);
    for (int i = 0; i < 10; i++) begin
      if (we || re) cnt++;
      step();
    end
    chk("bad_no_strobe", cnt, 32'd0);
    chk("bad_repeat_status", status, 32'h0580_0005);

    // NOP tag 07
    cmd = 32'h0700_0000;
    step();
    chk("nop_busy", status, 32'h05A0_0005);
    step(); step();
    chk("nop_status", status, 32'h0700_0006);
    chk("nop_rdata_kept", rdata, 32'h12345678);

    // reset in the middle of an access
    cmd = 32'h0840_0080; wdata = 32'h55AA;
    step(); step();
    chk("rst_mid_we_before", {31'b0, we}, 32'h1);
    #1 rst = 1'b1; #1;
    chk("rst_mid_we_drop", {31'b0, we}, 32'h0);
    cmd = '0; wdata = '0;
    step(); rst = 1'b0; step(); step();
    chk("rst_mid_status", status, 32'h0);
    chk("rst_mid_rdata", rdata, 32'h0);
    chk("rst_mid_addr", {16'b0, busAddr}, 32'h0);
    chk("rst_mid_wdata", busWdata, 32'h0);
    chk("rst_mid_strobes", {30'b0, we, re}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end
endmodule
